// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among N_CLI clients.
// Each grant runs IDLE -> ACCESS -> RELEASE; an ACCESS that outlives TIMEOUT cycles completes with cli_err.
module mem_port_arbiter #(
  parameter int N_CLI   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  localparam int GID_W  = $clog2(N_CLI)
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [N_CLI-1:0]          cli_req,
  input  logic [N_CLI-1:0]          cli_w_en,
  input  logic [N_CLI*ADDR_W-1:0]   cli_ptr,
  input  logic [N_CLI*DATA_W-1:0]   cli_data_store,
  output logic [N_CLI-1:0]          cli_done,
  output logic                      cli_err,
  output logic [DATA_W-1:0]         cli_data_load,
  output logic [ADDR_W-1:0]         mem_ptr,
  output logic [DATA_W-1:0]         mem_data_store,
  output logic                      mem_w_en,
  output logic                      mem_r_en,
  output logic                      mem_avail,
  input  logic                      mem_done,
  input  logic [DATA_W-1:0]         mem_data_load,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [GID_W-1:0]    last_q, last_d;
  logic [GID_W-1:0]    grant_id_q, grant_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CLI-1:0]    cli_done_q, cli_done_d;
  logic                cli_err_q, cli_err_d;
  logic [DATA_W-1:0]   cli_data_load_q, cli_data_load_d;
  logic [ADDR_W-1:0]   mem_ptr_q, mem_ptr_d;
  logic [DATA_W-1:0]   mem_data_store_q, mem_data_store_d;
  logic                mem_w_en_q, mem_w_en_d;
  logic                mem_r_en_q, mem_r_en_d;
  logic                mem_avail_q, mem_avail_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [GID_W-1:0]    winner;
  logic                mem_fire;
  logic                time_up;

  // Search upward from the client after the last grant so the last winner ends up lowest priority.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int k = 1; k <= N_CLI; k++) begin
      if (!win_found && cli_req[(int'(last_q) + k) % N_CLI]) begin
        win_found = 1'b1;
        winner    = GID_W'((int'(last_q) + k) % N_CLI);
      end
    end
  end

  assign mem_fire = mem_done & mem_avail_q;
  assign time_up  = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    grant_id_d       = grant_id_q;
    cnt_d            = cnt_q;
    cli_done_d       = cli_done_q;
    cli_err_d        = cli_err_q;
    cli_data_load_d  = cli_data_load_q;
    mem_ptr_d        = mem_ptr_q;
    mem_data_store_d = mem_data_store_q;
    mem_w_en_d       = mem_w_en_q;
    mem_r_en_d       = mem_r_en_q;
    mem_avail_d      = mem_avail_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = ACCESS;
          grant_id_d       = winner;
          mem_ptr_d        = cli_ptr[int'(winner)*ADDR_W +: ADDR_W];
          mem_data_store_d = cli_data_store[int'(winner)*DATA_W +: DATA_W];
          mem_w_en_d       = cli_w_en[winner];
          mem_r_en_d       = ~cli_w_en[winner];
          mem_avail_d      = 1'b1;
          cnt_d            = '0;
        end
      end
      ACCESS: begin
        if (mem_fire || time_up) begin
          state_d                = RELEASE;
          mem_avail_d            = 1'b0;
          mem_w_en_d             = 1'b0;
          mem_r_en_d             = 1'b0;
          cli_done_d             = '0;
          cli_done_d[grant_id_q] = 1'b1;
          cli_err_d              = ~mem_fire;
          if (mem_fire && mem_r_en_q) begin
            cli_data_load_d = mem_data_load;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d    = IDLE;
        cli_done_d = '0;
        cli_err_d  = 1'b0;
        last_d     = grant_id_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Reset forces every output low at once, abandoning any in-flight access.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q          <= IDLE;
      last_q           <= GID_W'(N_CLI - 1);
      grant_id_q       <= '0;
      cnt_q            <= '0;
      cli_done_q       <= '0;
      cli_err_q        <= 1'b0;
      cli_data_load_q  <= '0;
      mem_ptr_q        <= '0;
      mem_data_store_q <= '0;
      mem_w_en_q       <= 1'b0;
      mem_r_en_q       <= 1'b0;
      mem_avail_q      <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_q           <= last_d;
      grant_id_q       <= grant_id_d;
      cnt_q            <= cnt_d;
      cli_done_q       <= cli_done_d;
      cli_err_q        <= cli_err_d;
      cli_data_load_q  <= cli_data_load_d;
      mem_ptr_q        <= mem_ptr_d;
      mem_data_store_q <= mem_data_store_d;
      mem_w_en_q       <= mem_w_en_d;
      mem_r_en_q       <= mem_r_en_d;
      mem_avail_q      <= mem_avail_d;
      busy_q           <= busy_d;
    end
  end

  assign cli_done       = cli_done_q;
  assign cli_err        = cli_err_q;
  assign cli_data_load  = cli_data_load_q;
  assign mem_ptr        = mem_ptr_q;
  assign mem_data_store = mem_data_store_q;
  assign mem_w_en       = mem_w_en_q;
  assign mem_r_en       = mem_r_en_q;
  assign mem_avail      = mem_avail_q;
  assign grant_id       = grant_id_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int N_CLI   = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int GID_W   = 2;

  logic                    clk;
  logic                    rst_l;
  logic [N_CLI-1:0]        cli_req;
  logic [N_CLI-1:0]        cli_w_en;
  logic [N_CLI*ADDR_W-1:0] cli_ptr;
  logic [N_CLI*DATA_W-1:0] cli_data_store;
  logic [N_CLI-1:0]        cli_done;
  logic                    cli_err;
  logic [DATA_W-1:0]       cli_data_load;
  logic [ADDR_W-1:0]       mem_ptr;
  logic [DATA_W-1:0]       mem_data_store;
  logic                    mem_w_en;
  logic                    mem_r_en;
  logic                    mem_avail;
  logic                    mem_done;
  logic [DATA_W-1:0]       mem_data_load;
  logic [GID_W-1:0]        grant_id;
  logic                    busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_last;
  logic [DATA_W-1:0] exp_load;

  mem_port_arbiter #(
    .N_CLI(N_CLI), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .cli_req(cli_req), .cli_w_en(cli_w_en), .cli_ptr(cli_ptr), .cli_data_store(cli_data_store),
    .cli_done(cli_done), .cli_err(cli_err), .cli_data_load(cli_data_load),
    .mem_ptr(mem_ptr), .mem_data_store(mem_data_store),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_avail(mem_avail),
    .mem_done(mem_done), .mem_data_load(mem_data_load),
    .grant_id(grant_id), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Round-robin rule: first requester found searching upward from last+1 with wrap.
  function automatic int rr_pick(input logic [N_CLI-1:0] req, input int last);
    for (int k = 1; k <= N_CLI; k++) begin
      if (req[(last + k) % N_CLI]) return (last + k) % N_CLI;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input logic w, input logic [ADDR_W-1:0] p,
                            input logic [DATA_W-1:0] d);
    cli_w_en[i]                     = w;
    cli_ptr[i*ADDR_W +: ADDR_W]     = p;
    cli_data_store[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic scramble_fields();
    for (int i = 0; i < N_CLI; i++) set_client(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_reset();
    logic [N_CLI+1+DATA_W+ADDR_W+DATA_W+3+GID_W+1-1:0] all_out;
    rst_l = 1'b0;
    cli_req = 4'($urandom);
    scramble_fields();
    mem_done = 1'b1;
    mem_data_load = $urandom;
    repeat (2) tick();
    all_out = {cli_done, cli_err, cli_data_load, mem_ptr, mem_data_store,
               mem_w_en, mem_r_en, mem_avail, grant_id, busy};
    n_cmp++;
    if (all_out !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
    end
    cli_req  = '0;
    mem_done = 1'b0;
    @(negedge clk) rst_l = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || mem_avail !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got busy=%b avail=%b expected 0 0", busy, mem_avail);
    end
    exp_last = N_CLI - 1;
    exp_load = '0;
  endtask

  task automatic test_single_write();
    scramble_fields();
    cli_req = 4'b0100;
    set_client(2, 1'b1, 32'h40, 32'hDEAD);
    tick();
    n_cmp++;
    if (mem_avail !== 1'b1 || grant_id !== 2'd2 || mem_ptr !== 32'h40 ||
        mem_data_store !== 32'hDEAD || mem_w_en !== 1'b1 || mem_r_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_grant: got avail=%b gid=%0d ptr=%h data=%h w=%b r=%b expected 1 2 40 dead 1 0",
               mem_avail, grant_id, mem_ptr, mem_data_store, mem_w_en, mem_r_en);
    end
    for (int c = 0; c < 2; c++) begin
      scramble_fields();
      mem_done = 1'b0;
      tick();
      n_cmp++;
      if (cli_done !== '0 || mem_avail !== 1'b1 || mem_ptr !== 32'h40 || mem_data_store !== 32'hDEAD) begin
        n_fail++;
        $display("[TB] FAIL write_hold: got done=%b avail=%b ptr=%h data=%h expected 0000 1 40 dead",
                 cli_done, mem_avail, mem_ptr, mem_data_store);
      end
    end
    mem_done = 1'b1;
    tick();
    n_cmp++;
    if (cli_done !== 4'b0100 || cli_err !== 1'b0 || mem_avail !== 1'b0 || grant_id !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL write_done: got done=%b err=%b avail=%b gid=%0d expected 0100 0 0 2",
               cli_done, cli_err, mem_avail, grant_id);
    end
    mem_done = 1'b0;
    cli_req  = '0;
    tick();
    n_cmp++;
    if (cli_done !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL write_release: got done=%b busy=%b expected 0000 0", cli_done, busy);
    end
    exp_last = 2;
  endtask

  task automatic test_read_then_write();
    scramble_fields();
    cli_req = 4'b0010;
    set_client(1, 1'b0, $urandom, $urandom);
    tick();
    n_cmp++;
    if (grant_id !== 2'd1 || mem_r_en !== 1'b1 || mem_w_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_grant: got gid=%0d r=%b w=%b expected 1 1 0", grant_id, mem_r_en, mem_w_en);
    end
    mem_done = 1'b1;
    mem_data_load = 32'h1234;
    tick();
    n_cmp++;
    if (cli_done !== 4'b0010 || cli_data_load !== 32'h1234) begin
      n_fail++;
      $display("[TB] FAIL read_data: got done=%b load=%h expected 0010 1234", cli_done, cli_data_load);
    end
    mem_done = 1'b0;
    mem_data_load = $urandom;
    cli_w_en[1] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (grant_id !== 2'd1 || mem_w_en !== 1'b1 || mem_avail !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rewrite_grant: got gid=%0d w=%b avail=%b expected 1 1 1", grant_id, mem_w_en, mem_avail);
    end
    mem_done = 1'b1;
    mem_data_load = 32'hFFFF_0000;
    tick();
    n_cmp++;
    if (cli_done !== 4'b0010 || cli_data_load !== 32'h1234) begin
      n_fail++;
      $display("[TB] FAIL write_keeps_load: got done=%b load=%h expected 0010 1234", cli_done, cli_data_load);
    end
    cli_req  = '0;
    mem_done = 1'b0;
    tick();
    exp_last = 1;
    exp_load = 32'h1234;
  endtask

  task automatic test_timeout();
    int acc = 0;
    bit seen = 0;
    cli_req = 4'b0001;
    set_client(0, 1'b0, $urandom, $urandom);
    mem_done = 1'b0;
    tick();
    for (int k = 0; k < 20 && !seen; k++) begin
      if (mem_avail === 1'b1) acc++;
      mem_data_load = $urandom;
      tick();
      if (cli_done !== '0) seen = 1;
    end
    n_cmp++;
    if (!seen || acc != TIMEOUT || cli_done !== 4'b0001 || cli_err !== 1'b1 || cli_data_load !== exp_load) begin
      n_fail++;
      $display("[TB] FAIL timeout: got seen=%0d cycles=%0d done=%b err=%b load=%h expected 1 %0d 0001 1 %h",
               seen, acc, cli_done, cli_err, cli_data_load, TIMEOUT, exp_load);
    end
    cli_req = '0;
    tick();
    n_cmp++;
    if (cli_err !== 1'b0 || cli_done !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_release: got err=%b done=%b busy=%b expected 0 0000 0", cli_err, cli_done, busy);
    end
    exp_last = 0;
  endtask

  task automatic test_drop_req();
    int w;
    int nxt;
    scramble_fields();
    cli_w_en = '1;
    cli_req  = 4'b0110;
    w = rr_pick(cli_req, exp_last);
    tick();
    n_cmp++;
    if (grant_id !== GID_W'(w) || mem_avail !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drop_grant: got gid=%0d avail=%b expected %0d 1", grant_id, mem_avail, w);
    end
    cli_req[w] = 1'b0;
    mem_done = 1'b0;
    tick();
    mem_done = 1'b1;
    tick();
    n_cmp++;
    if (cli_done !== (4'b0001 << w)) begin
      n_fail++;
      $display("[TB] FAIL drop_done: got %b expected %b", cli_done, 4'b0001 << w);
    end
    exp_last = w;
    nxt = rr_pick(cli_req, exp_last);
    mem_done = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (grant_id !== GID_W'(nxt) || mem_avail !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drop_next: got gid=%0d avail=%b expected %0d 1", grant_id, mem_avail, nxt);
    end
    mem_done = 1'b1;
    tick();
    cli_req  = '0;
    mem_done = 1'b0;
    tick();
    exp_last = nxt;
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int last_cyc = 0;
    int cyc = 0;
    int exp_g;
    logic prev_avail;
    scramble_fields();
    cli_w_en = '1;
    cli_req  = '1;
    mem_done = 1'b0;
    prev_avail = mem_avail;
    while (cyc < 60 && grants < 8) begin
      mem_done = mem_avail;
      tick();
      cyc++;
      if (mem_avail === 1'b1 && prev_avail !== 1'b1) begin
        exp_g = rr_pick(cli_req, exp_last);
        n_cmp++;
        if (grant_id !== GID_W'(exp_g)) begin
          n_fail++;
          $display("[TB] FAIL rr_order: got gid=%0d expected %0d", grant_id, exp_g);
        end
        if (grants > 0) begin
          n_cmp++;
          if (cyc - last_cyc != 3) begin
            n_fail++;
            $display("[TB] FAIL rr_spacing: got %0d cycles expected 3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        exp_last = exp_g;
        grants++;
      end
      prev_avail = mem_avail;
    end
    n_cmp++;
    if (grants != 8) begin
      n_fail++;
      $display("[TB] FAIL rr_count: got %0d grants expected 8", grants);
    end
    cli_req  = '0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int phase = 0;
    int g = exp_last;
    int lat = 0;
    bit just_granted = 0;
    logic [N_CLI-1:0]  req_drv = '0;
    logic [N_CLI-1:0]  exp_done_vec = '0;
    logic [ADDR_W-1:0] exp_ptr = '0;
    logic [DATA_W-1:0] exp_store = '0;
    logic              exp_w = 1'b0;
    for (int cyc = 0; cyc < 440; cyc++) begin
      n_cmp++;
      if (mem_avail !== (phase == 1) || busy !== (phase != 0)) begin
        n_fail++;
        $display("[TB] FAIL rand_phase: cyc %0d got avail=%b busy=%b expected %b %b",
                 cyc, mem_avail, busy, phase == 1, phase != 0);
      end
      n_cmp++;
      if (cli_done !== exp_done_vec || cli_err !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rand_done: cyc %0d got done=%b err=%b expected %b 0", cyc, cli_done, cli_err, exp_done_vec);
      end
      n_cmp++;
      if (cli_data_load !== exp_load) begin
        n_fail++;
        $display("[TB] FAIL rand_load: cyc %0d got %h expected %h", cyc, cli_data_load, exp_load);
      end
      if (just_granted) begin
        n_cmp++;
        if (grant_id !== GID_W'(g) || mem_ptr !== exp_ptr || mem_data_store !== exp_store ||
            mem_w_en !== exp_w || mem_r_en !== ~exp_w) begin
          n_fail++;
          $display("[TB] FAIL rand_grant: cyc %0d got gid=%0d ptr=%h data=%h w=%b r=%b expected %0d %h %h %b %b",
                   cyc, grant_id, mem_ptr, mem_data_store, mem_w_en, mem_r_en, g, exp_ptr, exp_store, exp_w, ~exp_w);
        end
      end
      just_granted = 0;

      // Granted client drops its request once it sees done; idle clients raise new ones at random.
      if (phase == 2) req_drv[g] = 1'b0;
      for (int i = 0; i < N_CLI; i++) begin
        if (cyc < 400 && !req_drv[i] && $urandom_range(0, 3) == 0) req_drv[i] = 1'b1;
      end
      scramble_fields();
      cli_req       = req_drv;
      mem_done      = 1'($urandom_range(0, 1));
      mem_data_load = $urandom;
      exp_done_vec  = '0;

      case (phase)
        0: begin
          if (req_drv != '0) begin
            g         = rr_pick(req_drv, exp_last);
            exp_ptr   = cli_ptr[g*ADDR_W +: ADDR_W];
            exp_store = cli_data_store[g*DATA_W +: DATA_W];
            exp_w     = cli_w_en[g];
            lat       = $urandom_range(0, 3);
            just_granted = 1;
            phase     = 1;
          end
        end
        1: begin
          if (lat == 0) begin
            mem_done        = 1'b1;
            exp_done_vec[g] = 1'b1;
            if (!exp_w) exp_load = mem_data_load;
            phase           = 2;
          end else begin
            mem_done = 1'b0;
            lat--;
          end
        end
        default: begin
          exp_last = g;
          phase    = 0;
        end
      endcase
      tick();
    end
    cli_req  = '0;
    mem_done = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [N_CLI+1+DATA_W+ADDR_W+DATA_W+3+GID_W+1-1:0] all_out;
    scramble_fields();
    cli_req  = 4'b1000;
    mem_done = 1'b0;
    tick();
    n_cmp++;
    if (grant_id !== GID_W'(rr_pick(4'b1000, exp_last)) || mem_avail !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_pre_grant: got gid=%0d avail=%b expected 3 1", grant_id, mem_avail);
    end
    tick();
    #2 rst_l = 1'b0;
    #1;
    all_out = {cli_done, cli_err, cli_data_load, mem_ptr, mem_data_store,
               mem_w_en, mem_r_en, mem_avail, grant_id, busy};
    n_cmp++;
    if (all_out !== '0) begin
      n_fail++;
      $display("[TB] FAIL rst_async: got %h expected 0", all_out);
    end
    mem_done = 1'b1;
    tick();
    n_cmp++;
    if (cli_done !== '0 || mem_avail !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_no_done: got done=%b avail=%b expected 0000 0", cli_done, mem_avail);
    end
    mem_done = 1'b0;
    exp_last = N_CLI - 1;
    exp_load = '0;
    @(negedge clk) rst_l = 1'b1;
    tick();
    n_cmp++;
    if (grant_id !== GID_W'(rr_pick(cli_req, exp_last)) || mem_avail !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_regrant: got gid=%0d avail=%b expected 3 1", grant_id, mem_avail);
    end
    mem_done = 1'b1;
    tick();
    n_cmp++;
    if (cli_done !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL rst_regrant_done: got %b expected 1000", cli_done);
    end
    mem_done = 1'b0;
    cli_req  = '0;
    tick();
    rst_l   = 1'b0;
    cli_req = 4'b1001;
    exp_last = N_CLI - 1;
    @(negedge clk) rst_l = 1'b1;
    tick();
    n_cmp++;
    if (grant_id !== GID_W'(rr_pick(cli_req, exp_last)) || mem_avail !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_first_winner: got gid=%0d avail=%b expected 0 1", grant_id, mem_avail);
    end
    cli_req = '0;
  endtask

  initial begin
    rst_l          = 1'b0;
    cli_req        = '0;
    cli_w_en       = '0;
    cli_ptr        = '0;
    cli_data_store = '0;
    mem_done       = 1'b0;
    mem_data_load  = '0;
    exp_last       = N_CLI - 1;
    exp_load       = '0;
    test_reset();
    test_single_write();
    test_read_then_write();
    test_timeout();
    test_drop_req();
    test_round_robin();
    test_random();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N_CLI, default 4, number of requesting clients (2..8) sharing one memory port.
REQ-002 Parameter ADDR_W, default 32, memory pointer width.
REQ-003 Parameter DATA_W, default 32, memory data width.
REQ-004 Parameter TIMEOUT, default 1024, maximum ACCESS cycles before abort (>=2).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_l  input  1  reset, asynchronous, active-low.
REQ-007 cli_req  input  N_CLI  per-client request; held high until that client's cli_done.
REQ-008 cli_w_en  input  N_CLI  per-client direction: 1 write, 0 read.
REQ-009 cli_ptr  input  N_CLI*ADDR_W  per-client address; client i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 cli_data_store  input  N_CLI*DATA_W  per-client write data, packed the same way as cli_ptr.
REQ-011 cli_done  output  N_CLI  one-cycle completion pulse to the granted client.
REQ-012 cli_err  output  1  one-cycle pulse coincident with cli_done when the access timed out.
REQ-013 cli_data_load  output  DATA_W  read data captured for the last completed read.
REQ-014 mem_ptr, mem_data_store  output  ADDR_W, DATA_W  memory address and write data.
REQ-015 mem_w_en, mem_r_en, mem_avail  output  1 each  memory write enable, read enable and request-valid.
REQ-016 mem_done  input  1  memory completion; qualified only while mem_avail=1.
REQ-017 mem_data_load  input  DATA_W  memory read data; valid in the cycle mem_done=1.
REQ-018 grant_id  output  $clog2(N_CLI)  index of the current or last granted client.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states are IDLE, ACCESS and RELEASE; all outputs are registered.
REQ-021 IDLE: when any cli_req bit is 1, select a winner round-robin, searching upward from (last+1) mod N_CLI with wrap-around; on the next edge move to ACCESS.
REQ-022 On IDLE->ACCESS: grant_id<=winner; mem_ptr and mem_data_store latch the winner's fields; mem_w_en<=cli_w_en[w]; mem_r_en<=~cli_w_en[w]; mem_avail<=1; timeout counter<=0.
REQ-023 Request-to-mem_avail latency is exactly 1 cycle from an IDLE cycle with cli_req asserted.
REQ-024 Memory outputs stay stable throughout ACCESS; client input changes during ACCESS are ignored.
REQ-025 ACCESS with mem_done=1: next edge clears mem_avail, mem_w_en and mem_r_en; sets cli_done[grant_id]=1; captures cli_data_load<=mem_data_load on reads only; moves to RELEASE.
REQ-026 ACCESS without mem_done: counter increments; at counter==TIMEOUT-1, take the same transition as REQ-025 with cli_err=1 and cli_data_load unchanged.
REQ-027 RELEASE: cli_done and cli_err return to 0; last<=grant_id; next edge moves to IDLE.
REQ-028 Minimum spacing between successive grants is 3 cycles; a client still requesting after its done pulse is treated as a new request at lowest priority.
REQ-029 Deassertion of the granted client's cli_req mid-ACCESS does not abort the access; its done pulse is still issued.
REQ-030 At most one cli_done bit is set in any cycle; grant never changes outside IDLE->ACCESS.

Reset
REQ-031 With rst_l=0: state=IDLE, last=N_CLI-1 (client 0 wins first), and all outputs 0, including grant_id, cli_data_load, mem_ptr and mem_data_store.
REQ-032 Reset asserted mid-ACCESS abandons the transaction immediately with no cli_done pulse; mem_avail drops asynchronously.

Verification
REQ-033 Single client 2 writes ptr=0x40 data=0xDEAD; mem_done after 3 cycles -> mem_avail high 1 cycle after req, then cli_done[2] pulses once and grant_id=2.
REQ-034 All 4 clients request continuously, mem_done after 1 cycle each -> grant order 0,1,2,3,0,... with 3-cycle grant spacing.
REQ-035 Client 1 reads; mem_data_load=0x1234 with mem_done -> cli_data_load=0x1234 in the cli_done[1] cycle; a following write leaves it at 0x1234.
REQ-036 mem_done never asserted, TIMEOUT=8 -> after 8 ACCESS cycles cli_done and cli_err pulse together and the FSM returns to IDLE.
REQ-037 rst_l driven low during ACCESS -> all outputs 0 at once, no done pulse; after release a pending request from client 3 is granted (last reset to 3 selects 0 first only if client 0 requests).
REQ-038 Granted client drops cli_req mid-access -> access completes and its done pulse is still issued; arbitration then moves to the next requester.
